// File: rtl/case_1_mul_share_arb.sv
// case_1_mul_share_arb
//   Round-robin arbiter that shares one signed multiplier among NUM_REQ
//   requesters. IDLE grants one request (searching upward from rr_ptr),
//   CALC registers the product, RESP holds it on a valid/ready channel.
//   Optional build macro: MUL_ARB_SAT_EN
//     defined   -> product saturates to the signed DOUT_WIDTH range
//     undefined -> product wraps to its low DOUT_WIDTH bits
module case_1_mul_share_arb #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DIN0_WIDTH = 6,
   parameter int DIN1_WIDTH = 6,
   parameter int DOUT_WIDTH = 7
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
   input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
   output logic                             resp_valid,
   input  logic                             resp_ready,
   output logic [ID_WIDTH-1:0]              resp_id,
   output logic [DOUT_WIDTH-1:0]            resp_dout,
   output logic                             busy
);

   // Requester slots are padded to a power of two so the index never overruns
   localparam int NSLOT = 1 << ID_WIDTH;
   localparam int PW    = DIN0_WIDTH + DIN1_WIDTH;
   localparam logic [ID_WIDTH-1:0] LAST_IDX  = ID_WIDTH'(NUM_REQ - 1);
   localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                       state_reg, state_next;
   logic [ID_WIDTH-1:0]          rr_ptr_reg;
   logic signed [DIN0_WIDTH-1:0] op_a_reg;
   logic signed [DIN1_WIDTH-1:0] op_b_reg;
   logic [ID_WIDTH-1:0]          id_reg;
   logic [DOUT_WIDTH-1:0]        dout_reg;

   logic [NSLOT-1:0]             valid_ext;
   logic signed [DIN0_WIDTH-1:0] din0_arr [NSLOT];
   logic signed [DIN1_WIDTH-1:0] din1_arr [NSLOT];
   logic                         grant_found;
   logic [ID_WIDTH-1:0]          grant_idx;
   logic [ID_WIDTH:0]            cand;
   logic                         grant_en;
   logic signed [DOUT_WIDTH-1:0] mul_result;

   // Unpack the requester buses into indexable slots; unused slots read as idle
   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         if (gi < NUM_REQ) begin : g_used
            assign valid_ext[gi] = req_valid[gi];
            assign din0_arr[gi]  = req_din0[gi*DIN0_WIDTH +: DIN0_WIDTH];
            assign din1_arr[gi]  = req_din1[gi*DIN1_WIDTH +: DIN1_WIDTH];
         end else begin : g_pad
            assign valid_ext[gi] = 1'b0;
            assign din0_arr[gi]  = '0;
            assign din1_arr[gi]  = '0;
         end
      end
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = grant_en && (grant_idx == ID_WIDTH'(gi));
      end
   endgenerate

   // Round-robin search: first valid requester at or after rr_ptr, wrapping
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_reg} + (ID_WIDTH + 1)'(k);
         if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
         if (!grant_found && valid_ext[cand[ID_WIDTH-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_WIDTH-1:0];
         end
      end
   end

   // State register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state_reg <= ST_IDLE;
      else           state_reg <= state_next;
   end

   // Next-state logic: IDLE -> CALC -> RESP -> IDLE
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: if (grant_found) state_next = ST_CALC;
         ST_CALC: state_next = ST_RESP;
         ST_RESP: if (resp_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM outputs; the grant is suppressed while reset is held
   always_comb begin
      grant_en   = (state_reg == ST_IDLE) && grant_found && ap_rst_n;
      resp_valid = (state_reg == ST_RESP);
      busy       = (state_reg != ST_IDLE);
   end

`ifdef MUL_ARB_SAT_EN
   localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (DOUT_WIDTH - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
   logic signed [PW-1:0] prod_full;
   assign prod_full = PW'(op_a_reg) * PW'(op_b_reg);

   // Clamp the full-width product into the signed output range
   always_comb begin
      if (prod_full > SAT_MAX)      mul_result = SAT_MAX[DOUT_WIDTH-1:0];
      else if (prod_full < SAT_MIN) mul_result = SAT_MIN[DOUT_WIDTH-1:0];
      else                          mul_result = prod_full[DOUT_WIDTH-1:0];
   end
`else
   // Multiplying at output width keeps exactly the low bits of the full product
   assign mul_result = DOUT_WIDTH'(op_a_reg) * DOUT_WIDTH'(op_b_reg);
`endif

   // Operand capture on grant, rr pointer advance, product register in CALC
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rr_ptr_reg <= '0;
         op_a_reg   <= '0;
         op_b_reg   <= '0;
         id_reg     <= '0;
         dout_reg   <= '0;
      end else begin
         if (grant_en) begin
            op_a_reg   <= din0_arr[grant_idx];
            op_b_reg   <= din1_arr[grant_idx];
            id_reg     <= grant_idx;
            rr_ptr_reg <= (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_WIDTH'(1);
         end
         if (state_reg == ST_CALC) dout_reg <= mul_result;
      end
   end

   assign resp_id   = id_reg;
   assign resp_dout = dout_reg;

endmodule

// File: tb/tb_case_1_mul_share_arb.sv
// Testbench for case_1_mul_share_arb: reset, directed vector table,
// round-robin order, backpressure, random traffic against a reference
// model, and reset in the middle of an operation.
module tb_case_1_mul_share_arb;

   localparam int N = 4;

   logic          ap_clk;
   logic          ap_rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*6-1:0] req_din0;
   logic [N*6-1:0] req_din1;
   logic          resp_valid;
   logic          resp_ready;
   logic [1:0]    resp_id;
   logic [6:0]    resp_dout;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   int rr_model = 0;
   bit pend [N];
   int opa  [N];
   int opb  [N];

   case_1_mul_share_arb dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_din0   (req_din0),
      .req_din1   (req_din1),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_dout  (resp_dout),
      .busy       (busy)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   typedef struct {
      int id;
      int a;
      int b;
      int exp_wrap;
      int exp_sat;
      int hold;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference product from plain integer arithmetic
   function automatic int ref_mul(input int a, input int b);
      int p;
      p = a * b;
`ifdef MUL_ARB_SAT_EN
      if (p > 63)  p = 63;
      if (p < -64) p = -64;
`else
      p = p & 127;
      if (p >= 64) p = p - 128;
`endif
      return p;
   endfunction

   // Reference arbitration: first pending requester at or after the pointer
   function automatic int model_grant(input int ptr);
      for (int k = 0; k < N; k++)
         if (pend[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = pend[i];
         req_din0[i*6 +: 6] = 6'(opa[i]);
         req_din1[i*6 +: 6] = 6'(opb[i]);
      end
   endtask

   task automatic cycle();
      @(posedge ap_clk);
      @(negedge ap_clk);
   endtask

   // One complete operation; inputs for the grant cycle are already driven
   task automatic txn(input int g, input int exp, input int hold, input bit drop, input string tag);
      #1;
      check({tag, " req_ready"}, int'(req_ready), 1 << g);
      check({tag, " busy_idle"}, int'(busy), 0);
      cycle();
      if (drop) begin
         pend[g] = 1'b0;
         drive_inputs();
      end
      #1;
      check({tag, " calc_ready"}, int'(req_ready), 0);
      check({tag, " calc_valid"}, int'(resp_valid), 0);
      check({tag, " calc_busy"}, int'(busy), 1);
      cycle();
      #1;
      check({tag, " resp_valid"}, int'(resp_valid), 1);
      check({tag, " resp_id"}, int'(resp_id), g);
      check({tag, " resp_dout"}, int'($signed(resp_dout)), exp);
      for (int h = 0; h < hold; h++) begin
         resp_ready = 1'b0;
         cycle();
         #1;
         check({tag, " hold_valid"}, int'(resp_valid), 1);
         check({tag, " hold_id"}, int'(resp_id), g);
         check({tag, " hold_dout"}, int'($signed(resp_dout)), exp);
         check({tag, " hold_ready"}, int'(req_ready), 0);
      end
      resp_ready = 1'b1;
      cycle();
      resp_ready = 1'b0;
      #1;
      check({tag, " done_valid"}, int'(resp_valid), 0);
      check({tag, " done_busy"}, int'(busy), 0);
      rr_model = (g + 1) % N;
      $display("txn %s: id=%0d dout=%0d expected=%0d hold=%0d", tag, resp_id, $signed(resp_dout), exp, hold);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      repeat (cycles) cycle();
      ap_rst_n = 1'b1;
      rr_model = 0;
   endtask

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1,   5,  -3, -15, -15,  0};
      vecs[1] = '{0,  31,  31, -63,  63,  0};
      vecs[2] = '{2, -32,  31,  32, -64,  0};
      vecs[3] = '{3, -32, -32,   0,  63,  0};
      vecs[4] = '{1,   8,   8, -64,  63, 10};
      vecs[5] = '{2,  -8,   8, -64, -64,  0};
      vecs[6] = '{3,  -1,  -1,   1,   1,  0};
      vecs[7] = '{0,   7,   9,  63,  63,  0};

      // Reset held with every requester valid: nothing granted
      ap_rst_n   = 1'b0;
      resp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b1;
         opa[i]  = i + 1;
         opb[i]  = -(i + 2);
      end
      drive_inputs();
      repeat (3) cycle();
      #1;
      check("rst req_ready", int'(req_ready), 0);
      check("rst resp_valid", int'(resp_valid), 0);
      check("rst busy", int'(busy), 0);
      check("rst resp_id", int'(resp_id), 0);
      check("rst resp_dout", int'(resp_dout), 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;

      // Round robin with everyone permanently valid: 0,1,2,3,0
      for (int k = 0; k < 5; k++)
         txn(k % N, ref_mul(opa[k % N], opb[k % N]), 0, 1'b0, $sformatf("rr%0d", k));

      // Directed vectors, one requester at a time
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      drive_inputs();
      do_reset(2);
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < N; i++) pend[i] = 1'b0;
         pend[vecs[v].id] = 1'b1;
         opa[vecs[v].id]  = vecs[v].a;
         opb[vecs[v].id]  = vecs[v].b;
         drive_inputs();
`ifdef MUL_ARB_SAT_EN
         txn(vecs[v].id, vecs[v].exp_sat, vecs[v].hold, 1'b1, $sformatf("vec%0d", v));
`else
         txn(vecs[v].id, vecs[v].exp_wrap, vecs[v].hold, 1'b1, $sformatf("vec%0d", v));
`endif
      end

      // Random traffic; pending requesters keep their operands until granted
      for (int t = 0; t < 40; t++) begin
         int g;
         bit any;
         any = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               pend[i] = 1'b1;
               opa[i]  = int'($urandom_range(0, 63)) - 32;
               opb[i]  = int'($urandom_range(0, 63)) - 32;
            end
            any |= pend[i];
         end
         if (!any) begin
            g = int'($urandom_range(0, N - 1));
            pend[g] = 1'b1;
            opa[g]  = int'($urandom_range(0, 63)) - 32;
            opb[g]  = int'($urandom_range(0, 63)) - 32;
         end
         drive_inputs();
         g = model_grant(rr_model);
         txn(g, ref_mul(opa[g], opb[g]), int'($urandom_range(0, 3)), 1'b1, $sformatf("rnd%0d", t));
      end

      // Reset during CALC: no response, pointer back to 0
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      pend[2] = 1'b1;
      opa[2]  = 3;
      opb[2]  = 4;
      drive_inputs();
      #1;
      check("midrst grant", int'(req_ready), 4);
      cycle();
      pend[2] = 1'b0;
      drive_inputs();
      #1;
      check("midrst in_calc", int'(busy), 1);
      ap_rst_n = 1'b0;
      #1;
      check("midrst busy", int'(busy), 0);
      check("midrst valid", int'(resp_valid), 0);
      cycle();
      ap_rst_n = 1'b1;
      rr_model = 0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         #1;
         check("midrst no_resp", int'(resp_valid), 0);
      end
      pend[1] = 1'b1; opa[1] = -6; opb[1] = 5;
      pend[3] = 1'b1; opa[3] = 2;  opb[3] = 2;
      drive_inputs();
      txn(1, ref_mul(-6, 5), 0, 1'b1, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
